pc_fetch: RTL and testbench

- Program-counter and instruction-fetch stage of the Hack-style CPU.
- Holds the 16-bit PC and advances it through the existing inc16 incrementer.
- Fetches from instruction memory over a req/ack handshake and presents each fetched word to the decode stage over a valid/ready handshake.
- Accepts jump redirects from the ALU/jump-condition logic, discarding any stale fetch.

---
 rtl/pc_fetch_pkg.sv | 13 +
 rtl/inc16.sv | 9 +
 rtl/pc_fetch.sv | 109 ++++++++++
 tb/tb_pc_fetch.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared state encodings and defaults for the fetch stage
package pc_fetch_pkg;

  localparam int          PC_WIDTH             = 16;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inc16.sv
// rtl/inc16.sv - 16-bit incrementer; carry out of bit 15 is discarded
module inc16 (
  input  logic [15:0] a,
  output logic [15:0] y
);

  assign y = a + 16'd1;

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction fetch stage
// Fetches over imem req/ack and hands words to decode over valid/ready.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] pc
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             redir_pend_q, redir_pend_d;
  logic [WIDTH-1:0] redir_addr_q, redir_addr_d;
  logic [WIDTH-1:0] pc_inc;

  inc16 u_inc16 (
    .a (pc_q),
    .y (pc_inc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (load) pc_d = load_addr;
      end

      ST_REQ: begin
        if (imem_ack) begin
          if (redir_pend_q || load) begin
            // Stale fetch: drop the data and restart at the newest target.
            pc_d         = load ? load_addr : redir_addr_q;
            redir_pend_d = 1'b0;
          end else begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
            pc_d       = pc_inc;
            state_d    = ST_HOLD;
          end
        end else if (load) begin
          // PC must stay stable while the request is outstanding.
          redir_pend_d = 1'b1;
          redir_addr_d = load_addr;
        end
      end

      ST_HOLD: begin
        if (load) begin
          pc_d    = load_addr;
          state_d = ST_REQ;
        end else if (instr_ready) begin
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      redir_pend_q <= 1'b0;
      redir_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
    end
  end

  // Decoded straight from state so reset drops them without waiting for a clock.
  assign imem_req    = (state_q == ST_REQ);
  assign instr_valid = (state_q == ST_HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] load_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc;

  logic        ack_auto;
  logic        ack_man;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  // Memory model: word at address A is 16'h1000 + A.
  assign imem_ack  = ack_auto ? imem_req : ack_man;
  assign imem_data = 16'h1000 + imem_addr;

  pc_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_addr   (load_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc          (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hold(input string tag, input logic [15:0] e_instr, input logic [15:0] e_ipc,
                          input logic [15:0] e_pc);
    chk({tag, "_valid"}, instr_valid, 1'b1);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_instr"}, instr, e_instr);
    chk({tag, "_ipc"}, instr_pc, e_ipc);
    chk({tag, "_pc"}, pc, e_pc);
  endtask

  task automatic chk_req(input string tag, input logic [15:0] e_addr);
    chk({tag, "_req"}, imem_req, 1'b1);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_addr"}, imem_addr, e_addr);
  endtask

  initial begin
    reset       = 1'b1;
    load        = 1'b0;
    load_addr   = 16'h0000;
    instr_ready = 1'b1;
    ack_auto    = 1'b1;
    ack_man     = 1'b0;

    #12;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_ipc", instr_pc, 16'h0000);
    reset = 1'b0;

    // Straight-line fetch, one instruction every two cycles.
    tick(); chk_req("sl_r0", 16'h0000);
    tick(); chk_hold("sl_h0", 16'h1000, 16'h0000, 16'h0001);
    tick(); chk_req("sl_r1", 16'h0001);
    tick(); chk_hold("sl_h1", 16'h1001, 16'h0001, 16'h0002);
    tick(); chk_req("sl_r2", 16'h0002);
    instr_ready = 1'b0;
    tick(); chk_hold("sl_h2", 16'h1002, 16'h0002, 16'h0003);

    // Backpressure.
    for (int i = 0; i < 4; i++) begin
      tick(); chk_hold("bp", 16'h1002, 16'h0002, 16'h0003);
    end

    // Wait states at address 5: three idle REQ cycles, ack on the fourth.
    ack_auto  = 1'b0;
    load      = 1'b1;
    load_addr = 16'h0005;
    tick(); chk_req("ws_c1", 16'h0005);
    load = 1'b0;
    tick(); chk_req("ws_c2", 16'h0005);
    tick(); chk_req("ws_c3", 16'h0005);
    tick(); chk_req("ws_c4", 16'h0005);
    ack_man = 1'b1;
    tick(); chk_hold("ws_h", 16'h1005, 16'h0005, 16'h0006);
    ack_man = 1'b0;

    // Jump while holding an instruction.
    load      = 1'b1;
    load_addr = 16'h0200;
    tick(); chk_req("jh", 16'h0200);

    // Jump coincident with ack: data dropped, new request at 0x300.
    load_addr = 16'h0300;
    ack_man   = 1'b1;
    tick(); chk_req("jack", 16'h0300);

    // Move to address 7 the same way, then redirect twice before the ack.
    load_addr = 16'h0007;
    tick(); chk_req("to7", 16'h0007);
    ack_man   = 1'b0;
    load_addr = 16'h0040;
    tick(); chk_req("jo_a", 16'h0007);
    load_addr = 16'h0050;
    tick(); chk_req("jo_b", 16'h0007);
    load = 1'b0;
    tick(); chk_req("jo_c", 16'h0007);
    ack_man = 1'b1;
    tick(); chk_req("jo_drop", 16'h0050);
    tick(); chk_hold("jo_h", 16'h1050, 16'h0050, 16'h0051);
    ack_man = 1'b0;

    // Wrap-around at 16'hFFFF.
    load      = 1'b1;
    load_addr = 16'hFFFF;
    tick(); chk_req("wr_r", 16'hFFFF);
    load    = 1'b0;
    ack_man = 1'b1;
    tick(); chk_hold("wr_h", 16'h0FFF, 16'hFFFF, 16'h0000);
    ack_man     = 1'b0;
    instr_ready = 1'b1;
    tick(); chk_req("wr_next", 16'h0000);

    // Leave a redirect pending at a non-reset PC, then reset asynchronously.
    load      = 1'b1;
    load_addr = 16'h1234;
    ack_man   = 1'b1;
    tick(); chk_req("ar_pc", 16'h1234);
    ack_man   = 1'b0;
    load_addr = 16'h0055;
    tick(); chk_req("ar_pend", 16'h1234);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_pc0", pc, 16'h0000);
    #1 reset = 1'b0;
    tick(); chk_req("ar_r", 16'h0000);
    ack_man = 1'b1;
    tick(); chk_hold("ar_h", 16'h1000, 16'h0000, 16'h0001);
    ack_man = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
